// File: rtl/dispatch_router.sv
// dispatch_router: in-order dispatch buffer. It steers the head instruction to its FU
// issue queue and tags each source operand with readiness from a per-PRN scoreboard.
module dispatch_router #(
    parameter int INST_ID_BITS = 6,
    parameter int PRN_BITS     = 6,
    parameter int MAX_OPERANDS = 3,
    parameter int FU_COUNT     = 4,
    parameter int BUF_DEPTH    = 4,
    localparam int FUC_BITS    = (FU_COUNT > 1) ? $clog2(FU_COUNT) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [INST_ID_BITS-1:0] in_inst_id,
    input  logic [31:0]             in_raw_instr,
    input  logic [63:0]             in_pc,
    input  logic [FUC_BITS-1:0]     in_fu_sel,
    input  logic                    in_prn_input_valid  [MAX_OPERANDS],
    input  logic [PRN_BITS-1:0]     in_prn_input        [MAX_OPERANDS],
    input  logic                    in_prn_output_valid [MAX_OPERANDS],
    input  logic [PRN_BITS-1:0]     in_prn_output       [MAX_OPERANDS],
    input  logic                    flush,
    input  logic                    set_prn_ready       [FU_COUNT][MAX_OPERANDS],
    input  logic [PRN_BITS-1:0]     set_prn             [FU_COUNT][MAX_OPERANDS],
    output logic                    inst_valid          [FU_COUNT],
    input  logic                    queue_ready         [FU_COUNT],
    output logic [INST_ID_BITS-1:0] inst_id,
    output logic [31:0]             raw_instr,
    output logic [63:0]             instr_pc,
    output logic                    prn_input_valid     [MAX_OPERANDS],
    output logic                    prn_input_ready     [MAX_OPERANDS],
    output logic [PRN_BITS-1:0]     prn_input           [MAX_OPERANDS],
    output logic                    prn_output_valid    [MAX_OPERANDS],
    output logic [PRN_BITS-1:0]     prn_output          [MAX_OPERANDS]
);

    localparam int PTR_BITS = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int CNT_BITS = $clog2(BUF_DEPTH + 1);
    localparam int SB_SIZE  = 1 << PRN_BITS;

    typedef struct packed {
        logic [INST_ID_BITS-1:0]               inst_id;
        logic [31:0]                           raw_instr;
        logic [63:0]                           pc;
        logic [FUC_BITS-1:0]                   fu_sel;
        logic [MAX_OPERANDS-1:0]               src_valid;
        logic [MAX_OPERANDS-1:0][PRN_BITS-1:0] src;
        logic [MAX_OPERANDS-1:0]               dst_valid;
        logic [MAX_OPERANDS-1:0][PRN_BITS-1:0] dst;
    } entry_t;

    entry_t              buf_q [BUF_DEPTH];
    entry_t              buf_d [BUF_DEPTH];
    logic [PTR_BITS-1:0] head_q, head_d;
    logic [PTR_BITS-1:0] tail_q, tail_d;
    logic [CNT_BITS-1:0] count_q, count_d;
    logic [SB_SIZE-1:0]  sb_q, sb_d;

    entry_t head_entry;
    entry_t in_entry;
    logic   not_empty;
    logic   do_enq;
    logic   do_disp;

    function automatic logic [PTR_BITS-1:0] ptr_inc(input logic [PTR_BITS-1:0] p);
        return (p == PTR_BITS'(BUF_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Flush masks the head's valid so no queue sees a handshake it would act on.
    always_comb begin
        head_entry = buf_q[head_q];
        not_empty  = (count_q != '0);
        in_ready   = (count_q != CNT_BITS'(BUF_DEPTH));
        do_disp    = 1'b0;
        for (int k = 0; k < FU_COUNT; k++) begin
            inst_valid[k] = not_empty && !flush && (head_entry.fu_sel == FUC_BITS'(k));
            if (inst_valid[k] && queue_ready[k]) begin
                do_disp = 1'b1;
            end
        end
        do_enq = in_valid && in_ready && !flush;
    end

    always_comb begin
        in_entry           = '0;
        in_entry.inst_id   = in_inst_id;
        in_entry.raw_instr = in_raw_instr;
        in_entry.pc        = in_pc;
        in_entry.fu_sel    = in_fu_sel;
        for (int o = 0; o < MAX_OPERANDS; o++) begin
            in_entry.src_valid[o] = in_prn_input_valid[o];
            in_entry.src[o]       = in_prn_input[o];
            in_entry.dst_valid[o] = in_prn_output_valid[o];
            in_entry.dst[o]       = in_prn_output[o];
        end
    end

    // A same-cycle completion broadcast bypasses the scoreboard for the head's sources.
    always_comb begin
        logic hit;
        inst_id   = head_entry.inst_id;
        raw_instr = head_entry.raw_instr;
        instr_pc  = head_entry.pc;
        for (int o = 0; o < MAX_OPERANDS; o++) begin
            prn_input_valid[o]  = head_entry.src_valid[o];
            prn_input[o]        = head_entry.src[o];
            prn_output_valid[o] = head_entry.dst_valid[o];
            prn_output[o]       = head_entry.dst[o];
            hit = sb_q[head_entry.src[o]];
            for (int f = 0; f < FU_COUNT; f++) begin
                for (int s = 0; s < MAX_OPERANDS; s++) begin
                    if (set_prn_ready[f][s] && (set_prn[f][s] == head_entry.src[o])) begin
                        hit = 1'b1;
                    end
                end
            end
            prn_input_ready[o] = !head_entry.src_valid[o] || hit;
        end
    end

    always_comb begin
        buf_d   = buf_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        sb_d    = sb_q;
        if (do_enq) begin
            buf_d[tail_q] = in_entry;
            tail_d        = ptr_inc(tail_q);
        end
        if (do_disp) begin
            head_d = ptr_inc(head_q);
        end
        if (do_enq && !do_disp) begin
            count_d = count_q + 1'b1;
        end else if (!do_enq && do_disp) begin
            count_d = count_q - 1'b1;
        end
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
        // Sets are applied before the dispatch clears so a colliding clear wins.
        for (int f = 0; f < FU_COUNT; f++) begin
            for (int o = 0; o < MAX_OPERANDS; o++) begin
                if (set_prn_ready[f][o]) begin
                    sb_d[set_prn[f][o]] = 1'b1;
                end
            end
        end
        if (do_disp) begin
            for (int o = 0; o < MAX_OPERANDS; o++) begin
                if (head_entry.dst_valid[o]) begin
                    sb_d[head_entry.dst[o]] = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BUF_DEPTH; i++) begin
                buf_q[i] <= '0;
            end
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            sb_q    <= '1;
        end else begin
            buf_q   <= buf_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            sb_q    <= sb_d;
        end
    end

endmodule
